// File: rtl/focus_pkg.sv
// Shared types and constants for the autofocus sweep controller and its lens stepper.
package focus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOME    = 3'd1,
    SETTLE  = 3'd2,
    ADVANCE = 3'd3,
    RETURN  = 3'd4,
    FINISH  = 3'd5
  } state_t;

  localparam int SIGMA_W = 9;
  localparam int IMEAN_W = 8;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/autofocus_sweep_ctrl_if.sv
// Lens stepper handshake. step_req rises with step_dir valid and holds until the first edge
// with step_ack=1; the step takes effect on that edge and step_req falls. step_ack with step_req=0 is ignored.
interface autofocus_sweep_ctrl_if;
  logic step_req;
  logic step_dir;
  logic step_ack;

  modport master (output step_req, output step_dir, input step_ack);
  modport slave  (input step_req, input step_dir, output step_ack);
endinterface

// File: rtl/lens_step_hs.sv
// One-at-a-time stepper command engine: owns the req/ack handshake and the tracked lens position.
module lens_step_hs
  import focus_pkg::*;
#(
  parameter int POS_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  input  logic             step_ack,
  output logic             step_req,
  output logic             step_dir,
  output logic [POS_W-1:0] lens_pos,
  output logic             cmd_done
);

  always_ff @(posedge clock) begin
    if (reset) begin
      step_req <= 1'b0;
      step_dir <= 1'b0;
      lens_pos <= '0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      if (step_req) begin
        if (step_ack) begin
          step_req <= 1'b0;
          cmd_done <= 1'b1;
          // Position saturates at both ends rather than wrapping.
          if (step_dir == DIR_UP) begin
            if (lens_pos != '1) lens_pos <= lens_pos + 1'b1;
          end else begin
            if (lens_pos != '0) lens_pos <= lens_pos - 1'b1;
          end
        end
      end else if (cmd_valid) begin
        step_req <= 1'b1;
        step_dir <= cmd_dir;
      end
    end
  end

endmodule

// File: rtl/autofocus_sweep_ctrl.sv
// Autofocus sweep sequencer: homes the lens, sweeps 0..POS_MAX sampling sharpness once per
// position, then parks on the sharpest position (or back at the start position on a weak run).
module autofocus_sweep_ctrl
  import focus_pkg::*;
#(
  parameter int POS_W         = 8,
  parameter int POS_MAX       = 200,
  parameter int SETTLE_FRAMES = 2,
  parameter int DARK_LVL      = 50,
  parameter int MIN_SIGMA     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hz,
  input  logic [SIGMA_W-1:0]  sigma,
  input  logic [IMEAN_W-1:0]  imean,
  input  logic                focus_bad,
  input  logic                auto_en,
  input  logic                start,
  input  logic                abort,
  autofocus_sweep_ctrl_if.master step,
  output logic [POS_W-1:0]    lens_pos,
  output logic [POS_W-1:0]    best_pos,
  output logic [SIGMA_W-1:0]  best_sigma,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output state_t              state_dbg
);

  localparam int CNT_W = 8;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [POS_W-1:0]   start_pos;
  logic               run_aborted;
  logic               focus_bad_d;
  logic               cmd_valid, cmd_dir, cmd_done;
  logic               hs_req, hs_dir;

  logic               trig, active, stop_req, low_sigma, sample_hit, outstanding;
  logic [POS_W-1:0]   target;
  logic [SIGMA_W-1:0] sample;

  lens_step_hs #(.POS_W(POS_W)) u_hs (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .step_ack  (step.step_ack),
    .step_req  (hs_req),
    .step_dir  (hs_dir),
    .lens_pos  (lens_pos),
    .cmd_done  (cmd_done)
  );

  assign step.step_req = hs_req;
  assign step.step_dir = hs_dir;
  assign state_dbg     = state;

  assign trig        = start | (auto_en & focus_bad & ~focus_bad_d);
  assign active      = (state == HOME) || (state == SETTLE) || (state == ADVANCE) || (state == RETURN);
  // An abort is held pending until any outstanding step has completed.
  assign stop_req    = active & (abort | run_aborted);
  assign low_sigma   = best_sigma < SIGMA_W'(MIN_SIGMA);
  assign target      = low_sigma ? start_pos : best_pos;
  assign sample      = (imean < IMEAN_W'(DARK_LVL)) ? '0 : sigma;
  assign sample_hit  = (state == SETTLE) && hz && (cnt == CNT_W'(SETTLE_FRAMES - 1)) && !stop_req;
  assign outstanding = hs_req | cmd_done;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_req) begin
      if (!hs_req) state_nxt = FINISH;
    end else begin
      case (state)
        IDLE:    if (trig && !abort) state_nxt = HOME;
        HOME:    if (!hs_req && lens_pos == '0) state_nxt = SETTLE;
        SETTLE:  if (sample_hit) state_nxt = ADVANCE;
        ADVANCE: begin
          if (cmd_done) state_nxt = SETTLE;
          else if (!hs_req && lens_pos == POS_W'(POS_MAX)) state_nxt = RETURN;
        end
        RETURN:  if (!hs_req && lens_pos == target) state_nxt = FINISH;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_dir   = DIR_DN;
    busy      = (state != IDLE);
    done      = (state == FINISH) && !(run_aborted || low_sigma);
    fail      = (state == FINISH) &&  (run_aborted || low_sigma);
    case (state)
      HOME: begin
        cmd_valid = (lens_pos != '0);
        cmd_dir   = DIR_DN;
      end
      ADVANCE: begin
        cmd_valid = (lens_pos != POS_W'(POS_MAX));
        cmd_dir   = DIR_UP;
      end
      RETURN: begin
        cmd_valid = (lens_pos != target);
        cmd_dir   = (lens_pos < target) ? DIR_UP : DIR_DN;
      end
      default: ;
    endcase
    // The cmd_done cycle is skipped so each request is preceded by at least one idle cycle.
    if (outstanding || stop_req) cmd_valid = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      start_pos   <= '0;
      best_pos    <= '0;
      best_sigma  <= '0;
      run_aborted <= 1'b0;
      focus_bad_d <= 1'b0;
    end else begin
      focus_bad_d <= focus_bad;
      if (state == IDLE && trig && !abort) begin
        start_pos   <= lens_pos;
        best_pos    <= '0;
        best_sigma  <= '0;
        run_aborted <= 1'b0;
      end
      if (active && abort) run_aborted <= 1'b1;
      if (state != SETTLE) cnt <= '0;
      else if (hz)         cnt <= cnt + 1'b1;
      // Strict compare keeps the earliest position on a tie.
      if (sample_hit && sample > best_sigma) begin
        best_sigma <= sample;
        best_pos   <= lens_pos;
      end
    end
  end

endmodule

// File: tb/tb_autofocus_sweep_ctrl.sv
// Directed bench for autofocus_sweep_ctrl with a small stepper responder and a scene model
// that maps the physical lens position to a sharpness value.
module tb_autofocus_sweep_ctrl;
  import focus_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               hz = 1'b0;
  logic [SIGMA_W-1:0] sigma = '0;
  logic [IMEAN_W-1:0] imean = '0;
  logic               focus_bad = 1'b0;
  logic               auto_en = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [7:0]         lens_pos, best_pos;
  logic [SIGMA_W-1:0] best_sigma;
  logic               busy, done, fail;
  state_t             state_dbg;

  autofocus_sweep_ctrl_if step_if();

  autofocus_sweep_ctrl #(
    .POS_W(8), .POS_MAX(4), .SETTLE_FRAMES(1), .DARK_LVL(50), .MIN_SIGMA(8)
  ) dut (
    .clock(clock), .reset(reset), .hz(hz), .sigma(sigma), .imean(imean),
    .focus_bad(focus_bad), .auto_en(auto_en), .start(start), .abort(abort),
    .step(step_if), .lens_pos(lens_pos), .best_pos(best_pos), .best_sigma(best_sigma),
    .busy(busy), .done(done), .fail(fail), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic               exp_q[$];
  logic [SIGMA_W-1:0] sig_tab [0:4];
  logic [IMEAN_W-1:0] im_val = 8'd100;
  int                 phys_pos = 0;
  int                 ack_delay = 2;
  int                 req_age = 0;
  logic               ack_dir = 1'b0;
  logic               exp_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_tab(input logic [8:0] a, b, c, d, e);
    sig_tab[0] = a; sig_tab[1] = b; sig_tab[2] = c; sig_tab[3] = d; sig_tab[4] = e;
  endtask

  task automatic push_seq(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == 8'h31);
  endtask

  // Stepper responder: acks ack_delay cycles after a request, checks direction order.
  initial begin
    step_if.step_ack = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        step_if.step_ack = 1'b0;
        req_age  = 0;
        phys_pos = 0;
      end else if (step_if.step_ack) begin
        step_if.step_ack = 1'b0;
        phys_pos = ack_dir ? phys_pos + 1 : phys_pos - 1;
        check("lens_track", 32'(lens_pos), 32'(phys_pos));
      end else if (step_if.step_req) begin
        req_age++;
        if (req_age >= ack_delay) begin
          step_if.step_ack = 1'b1;
          req_age = 0;
          ack_dir = step_if.step_dir;
          if (exp_q.size() == 0) check("step_unexp", 32'(step_if.step_req), 32'd0);
          else begin
            exp_dir = exp_q.pop_front();
            check("step_dir", 32'(step_if.step_dir), 32'(exp_dir));
          end
        end
      end else begin
        req_age = 0;
      end
    end
  end

  // Frame strobe every 5 cycles; sharpness follows the physical lens position.
  initial begin
    forever begin
      repeat (4) @(posedge clock);
      #1;
      hz    = 1'b1;
      sigma = (phys_pos >= 0 && phys_pos <= 4) ? sig_tab[phys_pos] : '0;
      imean = im_val;
      @(posedge clock); #1;
      hz = 1'b0;
    end
  end

  task automatic pulse_start(input string tag);
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_run(input string tag, input int e_done, input int e_fail, input int e_lens);
    int nd = 0;
    int nf = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      nd += int'(done);
      nf += int'(fail);
      if (!busy) break;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(nd), 32'(e_done));
    check({tag, "_fail"}, 32'(nf), 32'(e_fail));
    check({tag, "_lens"}, 32'(lens_pos), 32'(e_lens));
    check({tag, "_qleft"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_req(input string tag, input logic want_up);
    int found = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clock); #1;
      if (step_if.step_req && (!want_up || step_if.step_dir)) begin
        found = 1;
        break;
      end
    end
    check({tag, "_req_seen"}, 32'(found), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_outs"}, 32'({step_if.step_req, step_if.step_dir, lens_pos, best_pos,
                               best_sigma, busy, done, fail}), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    int busy_cycles;
    set_tab(9'd0, 9'd0, 9'd90, 9'd0, 9'd0);
    repeat (3) @(posedge clock);
    #1;
    check_reset_outs("rst0");
    reset = 1'b0;

    // From 0: no homing, sweep up, return to the peak at 2.
    push_seq("111100");
    pulse_start("pre");
    finish_run("pre", 1, 0, 2);
    check("pre_bsig", 32'(best_sigma), 32'd90);

    set_tab(9'd10, 9'd30, 9'd50, 9'd40, 9'd20);
    push_seq("00111100");
    pulse_start("t1");
    finish_run("t1", 1, 0, 2);
    check("t1_bpos", 32'(best_pos), 32'd2);
    check("t1_bsig", 32'(best_sigma), 32'd50);

    // Dark scene: every sample counts as zero, lens goes back to the start position.
    im_val = 8'd20;
    set_tab(9'd100, 9'd100, 9'd100, 9'd100, 9'd100);
    push_seq("00111100");
    pulse_start("dark");
    finish_run("dark", 0, 1, 2);
    check("dark_bsig", 32'(best_sigma), 32'd0);
    im_val = 8'd100;

    // Tie between positions 1 and 2 resolves to the earlier one.
    set_tab(9'd10, 9'd50, 9'd50, 9'd20, 9'd5);
    push_seq("001111000");
    pulse_start("tie");
    finish_run("tie", 1, 0, 1);
    check("tie_bpos", 32'(best_pos), 32'd1);
    check("tie_bsig", 32'(best_sigma), 32'd50);

    // abort in IDLE, together with start, has no effect.
    @(posedge clock); #1; abort = 1'b1; start = 1'b1;
    @(posedge clock); #1; abort = 1'b0; start = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_lens", 32'(lens_pos), 32'd1);

    // Abort during an up-step: step completes, then fail with no return.
    ack_delay = 5;
    set_tab(9'd10, 9'd30, 9'd50, 9'd40, 9'd20);
    push_seq("01");
    pulse_start("abt");
    wait_req("abt", 1'b1);
    @(posedge clock); #1; abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    finish_run("abt", 0, 1, 1);
    check("abt_req_low", 32'(step_if.step_req), 32'd0);
    ack_delay = 2;

    // Auto trigger on focus_bad rising edge; holding it high does not retrigger.
    push_seq("0111100");
    auto_en = 1'b1;
    @(posedge clock); #1; focus_bad = 1'b1;
    @(posedge clock); #1;
    check("auto_busy", 32'(busy), 32'd1);
    finish_run("auto", 1, 0, 2);
    check("auto_bpos", 32'(best_pos), 32'd2);
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      busy_cycles += int'(busy);
    end
    check("auto_no_retrig", 32'(busy_cycles), 32'd0);
    focus_bad = 1'b0;
    auto_en   = 1'b0;

    // Reset while a step request is outstanding.
    push_seq("00111100");
    pulse_start("rmid");
    wait_req("rmid", 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_outs("rmid");
    exp_q.delete();
    reset = 1'b0;
    push_seq("111100");
    pulse_start("rehome");
    finish_run("rehome", 1, 0, 2);
    check("rehome_bsig", 32'(best_sigma), 32'd50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
